// File: rtl/binary_to_bcd_serial_if.sv
// Valid/ready bundle between a binary producer, the serial BCD converter and
// the display path that consumes the packed BCD result.
interface binary_to_bcd_serial_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;

  // Producer/consumer side drives the requests and takes the result.
  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd
  );

  // Converter side.
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd
  );
endinterface

// File: rtl/binary_to_bcd_serial.sv
// Sequential double-dabble converter: one shift per clock, IN_WIDTH shifts
// per conversion, result held in a dedicated register until the next one
// completes. The caller must size DIGITS so 10^DIGITS > 2^IN_WIDTH - 1.
module binary_to_bcd_serial #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  binary_to_bcd_serial_if.slave bus,
  output logic                  busy
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IN_WIDTH-1:0] sh;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       acc_shift;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bcd_q;
  logic                accept;
  logic                last_shift;

  // Add-3 correction on every nibble, all tested on their pre-adjust value.
  // The top nibble is adjusted too so an out-of-range value stays contained.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (acc[4*g +: 4] >= 4'd5) ? acc[4*g +: 4] + 4'd3
                                                    : acc[4*g +: 4];
  end

  // The binary MSB enters the accumulator LSB on each shift.
  assign acc_shift  = {adj[BW-2:0], sh[IN_WIDTH-1]};
  assign last_shift = (state == SHIFT) && (cnt == CW'(1));
  assign accept     = bus.in_valid && bus.in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; DONE can hand straight to SHIFT when a
  // new value arrives in the same cycle the result is taken.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers: load on accept, shift/adjust/count while converting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      sh  <= bus.in_bin;
      acc <= '0;
      cnt <= CW'(IN_WIDTH);
    end else if (state == SHIFT) begin
      sh  <= {sh[IN_WIDTH-2:0], 1'b0};
      acc <= acc_shift;
      cnt <= cnt - CW'(1);
    end
  end

  // Result register: updated only on the final shift, so the display never
  // sees partial accumulator contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             bcd_q <= '0;
    else if (last_shift) bcd_q <= acc_shift;
  end

  assign bus.out_bcd = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_serial.sv
// Bench for binary_to_bcd_serial (IN_WIDTH=8, DIGITS=3): directed corner
// values, back-pressure, streaming, reset abort and random values, all
// compared against a decimal-arithmetic reference.
module tb_binary_to_bcd_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   vec = 0;
  int   err = 0;
  logic [11:0] last_bcd = '0;

  binary_to_bcd_serial_if #(.IN_WIDTH(8), .DIGITS(3)) bus ();

  binary_to_bcd_serial #(.IN_WIDTH(8), .DIGITS(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: accept, count busy cycles, check result, optionally
  // hold off the consumer for `hold` cycles, then complete the handshake.
  task automatic run_one(input logic [7:0] v, input int hold);
    int cyc;
    int nbusy;
    logic [11:0] exp;
    exp = to_bcd(int'(v));
    bus.in_bin   = v;
    bus.in_valid = 1'b1;
    vec++;
    if (bus.in_ready !== 1'b1) begin
      err++; $display("FAIL accept_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_bin   = 8'($urandom);
    cyc = 0;
    nbusy = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nbusy++;
      vec++;
      if (bus.out_bcd !== last_bcd) begin
        err++; $display("FAIL hold_prev(%0d): got %h expected %h", v, bus.out_bcd, last_bcd);
      end
      step();
      cyc++;
    end
    vec++;
    if (cyc != 8) begin
      err++; $display("FAIL latency(%0d): got %0d expected 8", v, cyc);
    end
    vec++;
    if (nbusy != 8) begin
      err++; $display("FAIL busy_cycles(%0d): got %0d expected 8", v, nbusy);
    end
    vec++;
    if (bus.out_bcd !== exp) begin
      err++; $display("FAIL result(%0d): got %h expected %h", v, bus.out_bcd, exp);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_bcd !== exp || bus.in_ready !== 1'b0) begin
        err++;
        $display("FAIL backpressure(%0d) cyc %0d: valid %b bcd %h rdy %b expected 1 %h 0",
                 v, i, bus.out_valid, bus.out_bcd, bus.in_ready, exp);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_bcd !== exp) begin
      err++;
      $display("FAIL release(%0d): valid %b bcd %h expected 0 %h", v, bus.out_valid, bus.out_bcd, exp);
    end
    last_bcd = exp;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_bin    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_bcd !== 12'h000) begin
      err++;
      $display("FAIL reset_state: rdy %b valid %b busy %b bcd %h expected 1 0 0 000",
               bus.in_ready, bus.out_valid, busy, bus.out_bcd);
    end
    rst = 1'b0;
    last_bcd = '0;
  endtask

  task automatic test_corners();
    run_one(8'd0, 0);
    run_one(8'd255, 0);
    run_one(8'd99, 1);
    run_one(8'd100, 0);
    run_one(8'd9, 2);
    run_one(8'd10, 0);
  endtask

  task automatic test_backpressure();
    run_one(8'd173, 20);
  endtask

  // in_valid and out_ready held high: accept every 9 cycles, result 8 later.
  task automatic test_back_to_back();
    int next_val;
    int got;
    int c;
    int q[$];
    logic [11:0] exp;
    next_val      = 1;
    got           = 0;
    c             = 0;
    bus.in_bin    = 8'd1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 20 && c < 400) begin
      vec++;
      if (bus.in_ready !== ((c % 9) == 0)) begin
        err++; $display("FAIL stream_ready c=%0d: got %b expected %b", c, bus.in_ready, (c % 9) == 0);
      end
      step();
      if ((c % 9) == 0 && next_val <= 20) begin
        q.push_back(next_val);
        next_val++;
        if (next_val > 20) bus.in_valid = 1'b0;
        else               bus.in_bin   = 8'(next_val);
      end
      vec++;
      if (bus.out_valid !== ((c % 9) == 8)) begin
        err++; $display("FAIL stream_valid c=%0d: got %b expected %b", c, bus.out_valid, (c % 9) == 8);
      end
      if (bus.out_valid === 1'b1) begin
        if (q.size() > 0) exp = to_bcd(q.pop_front());
        else              exp = 12'hxxx;
        vec++;
        if (bus.out_bcd !== exp) begin
          err++; $display("FAIL stream_result c=%0d: got %h expected %h", c, bus.out_bcd, exp);
        end
        last_bcd = exp;
        got++;
      end else begin
        vec++;
        if (bus.out_bcd !== last_bcd) begin
          err++; $display("FAIL stream_stable c=%0d: got %h expected %h", c, bus.out_bcd, last_bcd);
        end
      end
      c++;
    end
    vec++;
    if (got != 20) begin
      err++; $display("FAIL stream_count: got %0d expected 20", got);
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      err++; $display("FAIL stream_drain: valid %b rdy %b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) run_one(8'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_mid();
    bus.in_bin   = 8'd200;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_bcd !== 12'h000) begin
      err++;
      $display("FAIL reset_mid: rdy %b valid %b busy %b bcd %h expected 1 0 0 000",
               bus.in_ready, bus.out_valid, busy, bus.out_bcd);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_bcd = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      vec++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        err++; $display("FAIL reset_no_valid cyc %0d: valid %b busy %b expected 0 0", i, bus.out_valid, busy);
      end
    end
    run_one(8'd42, 0);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_serial.md
# binary_to_bcd_serial

Sequential double-dabble converter. It turns an unsigned binary value into packed BCD digits, one shift per clock. It sits directly upstream of the decimal seven-segment decoders: each 4-bit digit of `out_bcd` drives one decoder's `digit` input. Input and output each use a valid/ready handshake, so a producer such as a counter or measurement register can hand over a value and the display path holds the result.

## Interface
Parameters:
- `IN_WIDTH`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD output digits.
  - Integration must guarantee 10^DIGITS > 2^IN_WIDTH − 1.
  - The RTL does not check this constraint.

Ports (reset is asynchronous and active-high):
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: producer presents `in_bin`.
- `in_ready` output 1: block can accept a value this cycle.
- `in_bin` input IN_WIDTH: unsigned binary value.
- `out_valid` output 1: `out_bcd` holds a completed conversion not yet consumed.
- `out_ready` input 1: consumer takes the result.
- `out_bcd` output 4*DIGITS: packed BCD; `[3:0]` is the ones digit, `[7:4]` tens, and so on.
- `busy` output 1: high while in state SHIFT.

## Operation
- States:
  - IDLE: awaiting input.
  - SHIFT: converting.
  - DONE: result offered.
- Working registers:
  - binary shift register, IN_WIDTH bits;
  - BCD accumulator, 4*DIGITS bits;
  - shift counter, $clog2(IN_WIDTH+1) bits.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - load the shift register with `in_bin`;
  - clear the accumulator;
  - set the counter to IN_WIDTH;
  - go to SHIFT.
- SHIFT, once per cycle:
  - add 3 to every accumulator nibble that is ≥5 (all nibbles tested in parallel, on pre-adjust values);
  - shift {accumulator, shift register} left by one; the shift register MSB enters the accumulator LSB;
  - decrement the counter.
  - On the cycle the counter goes 1→0: copy the post-shift accumulator into the `out_bcd` register and go to DONE.
- DONE: `out_valid`=1.
  - On `out_ready`: go to IDLE.
  - If `in_valid` is also high in that same cycle: accept the new value directly and go to SHIFT, skipping IDLE.
  - Hence `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). This is the only combinational input→output path.
- `out_bcd` is a dedicated register:
  - it changes only at conversion completion;
  - it keeps the last result after the handshake and throughout the next conversion;
  - it never shows intermediate accumulator values.
- Arithmetic:
  - all nibble adds are 4-bit; values never exceed 12 before the shift, so no carry out of a nibble;
  - the top nibble's adjust is still applied so that any overflow beyond DIGITS stays contained;
  - results are exact when the parameter constraint holds.
- `in_bin` is sampled only on the accept edge; later changes are ignored.
- `out_ready` is ignored outside DONE. `in_valid` is ignored in SHIFT.

## Timing
- Reset (asynchronous assert, sync release) returns:
  - state = IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `out_bcd`=0; working registers 0.
- Reset during SHIFT or DONE discards the conversion. No `out_valid` pulse follows.
- Latency: accept on edge E0 → `out_valid` high after edge E(IN_WIDTH). For IN_WIDTH=8 that is 8 cycles.
- `busy` is high for exactly IN_WIDTH cycles per conversion.
- Throughput:
  - with `out_ready` held high and `in_valid` continuously high, one result every IN_WIDTH+1 cycles;
  - otherwise IN_WIDTH+2 cycles (via IDLE).
- Back-pressure: `out_valid` and `out_bcd` stay stable while `out_ready`=0, for unlimited time.
- `out_valid` falls on the edge after the handshake, unless a new conversion completes (not possible within 1 cycle).

## Test plan
- Reset, then `in_bin`=0 with `in_valid` one cycle:
  - `busy` high 8 cycles;
  - then `out_valid`=1, `out_bcd`=12'h000.
- `in_bin`=255:
  - `out_bcd`=12'h255 exactly 8 cycles after accept.
- `in_bin`=99, then 100, 9, 10:
  - `out_bcd`=12'h099, 12'h100, 12'h009, 12'h010 respectively.
- Back-pressure on 173:
  - hold `out_ready`=0 for 20 cycles after `out_valid` rises;
  - `out_bcd`=12'h173 stable and `in_ready`=0 throughout;
  - release → `out_valid` drops next cycle.
- Streaming 1,2,…,20 with `in_valid` and `out_ready` tied high:
  - one result per 9 cycles, in order, no drops;
  - `out_bcd` never shows intermediate values.
- Reset pulse 4 cycles into converting 200:
  - all outputs at reset values;
  - no `out_valid`;
  - next conversion of 42 yields 12'h042.
